// File: rtl/prbs_rr_arbiter.sv
// prbs_rr_arbiter: shares one PRBS generator round-robin across requesters, after a post-reset warm-up
// Ports: clk; rstn (sync, active-low); enable, req[NUM_REQ] in; gnt (one-hot pulse), rnd_out,
//        rnd_valid, ready, grant_cnt out; prbs_advance out / prbs_do in connect to the prbs block.
module prbs_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 31,
    parameter int WARMUP  = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [WIDTH-1:0]   rnd_out,
    output logic               rnd_valid,
    output logic               ready,
    output logic [31:0]        grant_cnt,
    output logic               prbs_advance,
    input  logic [WIDTH-1:0]   prbs_do
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    typedef enum logic {WARM, SERVE} state_t;

    state_t             state_q, state_d;
    logic [31:0]        warm_q, warm_d;
    logic [PW-1:0]      last_q, last_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [WIDTH-1:0]   rnd_q, rnd_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0] eligible;
    logic [PW-1:0]      win, idx;
    logic               found, grant;
    int                 j;

    always_comb begin
        // last cycle's winner is masked so a held request is not served twice in a row
        eligible = req & ~gnt_q;
        found = 1'b0;
        win = last_q;
        j = 0;
        idx = '0;
        // scan downward so the nearest eligible requester after last_q is the final assignment
        for (int i = NUM_REQ; i >= 1; i--) begin
            j = int'(last_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            idx = PW'(j);
            if (eligible[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
        grant = rstn & (state_q == SERVE) & enable & found;
        prbs_advance = rstn & ((state_q == WARM) | grant);
        state_d = state_q;
        warm_d = warm_q;
        if (state_q == WARM) begin
            warm_d = warm_q + 32'd1;
            if (warm_q == 32'(WARMUP - 1)) state_d = SERVE;
        end
        ready_d = (state_d == SERVE);
        gnt_d = grant ? {{(NUM_REQ-1){1'b0}}, 1'b1} << win : '0;
        rnd_d = grant ? prbs_do : rnd_q;
        valid_d = grant;
        last_d = grant ? win : last_q;
        cnt_d = cnt_q + {31'd0, grant};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= (WARMUP == 0) ? SERVE : WARM;
            warm_q  <= '0;
            last_q  <= PW'(NUM_REQ - 1);
            gnt_q   <= '0;
            rnd_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            rnd_q   <= rnd_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign rnd_out   = rnd_q;
    assign rnd_valid = valid_q;
    assign ready     = ready_q;
    assign grant_cnt = cnt_q;
endmodule

// File: tb/tb_prbs_rr_arbiter.sv
// tb_prbs_rr_arbiter: directed plus randomized checks of prbs_rr_arbiter against a behavioural model
module tb_prbs_rr_arbiter;
    localparam int N = 4, W = 31, WU = 32;

    logic clk = 1'b0, rstn = 1'b0, enable = 1'b0;
    logic [N-1:0] req = '0, gnt;
    logic [W-1:0] rnd_out, prbs_do;
    logic rnd_valid, ready, prbs_advance;
    logic [31:0] grant_cnt;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    prbs_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .WARMUP(WU)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .req(req), .gnt(gnt),
        .rnd_out(rnd_out), .rnd_valid(rnd_valid), .ready(ready),
        .grant_cnt(grant_cnt), .prbs_advance(prbs_advance), .prbs_do(prbs_do)
    );

    // stand-in prbs block: x^31+x^28+1, seed 1, presents the inverted next state
    function automatic logic [30:0] nx(input logic [30:0] v);
        return {v[29:0], v[30] ^ v[27]};
    endfunction
    logic [30:0] s;
    always_ff @(posedge clk) if (!rstn) s <= 31'd1; else if (prbs_advance) s <= nx(s);
    assign prbs_do = ~nx(s);

    // golden sequence: gold[k] is the generator state after k advances from seed 1
    logic [30:0] gold [0:1023];

    // behavioural model state
    bit m_ready;
    int warm, last, adv, pulses;
    logic [N-1:0] m_gnt;
    logic [31:0] m_cnt;
    logic [W-1:0] m_rnd, prev_rnd;
    bit m_valid, have_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock cycle: apply inputs, check the combinational advance, then the registered outputs
    task automatic cyc(input logic [N-1:0] r, input logic en, input logic rs);
        int win;
        logic [N-1:0] elig;
        logic exp_adv;
        req = r; enable = en; rstn = rs;
        #1;
        win = -1;
        elig = r & ~m_gnt;
        if (rs && m_ready && en)
            for (int k = 1; k <= N; k++)
                if (win < 0 && elig[(last + k) % N]) win = (last + k) % N;
        exp_adv = rs && (!m_ready || win >= 0);
        chk("prbs_advance", {63'd0, prbs_advance}, {63'd0, exp_adv});
        if (prbs_advance === 1'b1) pulses++;
        @(posedge clk); #1;
        if (!rs) begin
            m_ready = 0; warm = 0; last = N - 1; adv = 0; m_gnt = '0;
            m_cnt = 0; m_rnd = '0; m_valid = 0; have_prev = 0;
        end else if (!m_ready) begin
            adv++; warm++;
            if (warm == WU) m_ready = 1;
            m_gnt = '0; m_valid = 0;
        end else if (win >= 0) begin
            m_rnd = ~gold[adv + 1];
            adv++; last = win; m_cnt++; m_valid = 1;
            m_gnt = '0; m_gnt[win] = 1'b1;
        end else begin
            m_gnt = '0; m_valid = 0;
        end
        chk("gnt", {60'd0, gnt}, {60'd0, m_gnt});
        chk("rnd_valid", {63'd0, rnd_valid}, {63'd0, m_valid});
        chk("rnd_out", {33'd0, rnd_out}, {33'd0, m_rnd});
        chk("ready", {63'd0, ready}, {63'd0, m_ready});
        chk("grant_cnt", {32'd0, grant_cnt}, {32'd0, m_cnt});
        if (m_valid) begin
            if (have_prev) begin
                total++;
                assert (rnd_out !== prev_rnd) else begin
                    bad++;
                    $error("FAIL rnd_repeat observed=%0h expected_not=%0h", rnd_out, prev_rnd);
                end
            end
            prev_rnd = rnd_out; have_prev = 1;
        end
    endtask

    initial begin
        gold[0] = 31'd1;
        for (int k = 1; k < 1024; k++) gold[k] = nx(gold[k-1]);
        m_gnt = '0; last = N - 1; m_ready = 0;
        @(posedge clk); #1;
        // reset for 3 cycles, then warm-up with every requester active
        for (int k = 0; k < 3; k++) cyc(4'b1111, 1'b1, 1'b0);
        pulses = 0;
        for (int k = 0; k < WU; k++) cyc(4'b1111, 1'b1, 1'b1);
        chk("warm_pulses", 64'(pulses), 64'(WU));
        chk("ready_after_warm", {63'd0, ready}, 64'd1);
        // single requester: every second cycle
        for (int k = 0; k < 10; k++) cyc(4'b0001, 1'b1, 1'b1);
        chk("single_cnt", {32'd0, grant_cnt}, 64'd5);
        // full contention: strictly cyclic, advance every cycle
        pulses = 0;
        for (int k = 0; k < 8; k++) cyc(4'b1111, 1'b1, 1'b1);
        chk("full_pulses", 64'(pulses), 64'd8);
        // bring last to 2, then partial contention wraps past idle requester 3
        cyc(4'b0100, 1'b1, 1'b1);
        cyc(4'b0101, 1'b1, 1'b1);
        chk("wrap_to_0", {60'd0, gnt}, 64'b0001);
        cyc(4'b0101, 1'b1, 1'b1);
        chk("then_2", {60'd0, gnt}, 64'b0100);
        // enable gating
        pulses = 0;
        for (int k = 0; k < 5; k++) cyc(4'b1111, 1'b0, 1'b1);
        chk("gated_pulses", 64'(pulses), 64'd0);
        cyc(4'b1111, 1'b1, 1'b1);
        chk("resume_at_3", {60'd0, gnt}, 64'b1000);
        for (int k = 0; k < 3; k++) cyc(4'b1111, 1'b1, 1'b1);
        // mid-operation reset during full contention
        cyc(4'b1111, 1'b1, 1'b0);
        chk("rst_cnt", {32'd0, grant_cnt}, 64'd0);
        pulses = 0;
        for (int k = 0; k < WU; k++) cyc(4'b1111, 1'b1, 1'b1);
        chk("rewarm_pulses", 64'(pulses), 64'(WU));
        // randomized traffic
        for (int k = 0; k < 300; k++) cyc(N'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
